// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// The optional signed datapath is enabled by defining DIV_SIGNED_EN.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Quotient reported for a zero divisor (all ones at any width).
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUO = '1;

  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_negate.sv
// Two's-complement negate: the ALU's bitwise inverter followed by an increment.
module div_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_neg
);

  logic [WIDTH-1:0] w_inv;

  assign w_inv = ~i_a;
  assign o_neg = w_inv + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/iter_divider.sv
// Restoring divider, one quotient bit per cycle; DIV_SIGNED_EN builds the
// operand/result negation and sign fix-up, otherwise op_signed is ignored.
// Handshake: start is sampled only in IDLE; ready pulses one cycle when results update.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_t       o_dbg_state
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_Q = {WIDTH{DIV_DBZ_QUO[0]}};

  div_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_dvd;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_neg_q, r_neg_r, r_dbz_pend, r_dbz, r_ready;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_quo_fix, w_rem_fix;
  logic             w_neg_q, w_neg_r;
  logic [WIDTH+1:0] w_trial;
  logic             w_unused_trial;

`ifdef DIV_SIGNED_EN
  logic             w_dvd_s, w_dvs_s;
  logic [WIDTH-1:0] w_dvd_n, w_dvs_n, w_quo_n, w_rem_n;

  assign w_dvd_s = op_signed & dividend[WIDTH-1];
  assign w_dvs_s = op_signed & divisor[WIDTH-1];

  div_negate #(.WIDTH(WIDTH)) u_neg_dvd (.i_a(dividend), .o_neg(w_dvd_n));
  div_negate #(.WIDTH(WIDTH)) u_neg_dvs (.i_a(divisor),  .o_neg(w_dvs_n));
  div_negate #(.WIDTH(WIDTH)) u_neg_quo (.i_a(r_quo),    .o_neg(w_quo_n));
  div_negate #(.WIDTH(WIDTH)) u_neg_rem (.i_a(r_rem),    .o_neg(w_rem_n));

  assign w_dvd_mag = w_dvd_s ? w_dvd_n : dividend;
  assign w_dvs_mag = w_dvs_s ? w_dvs_n : divisor;
  assign w_neg_q   = w_dvd_s ^ w_dvs_s;
  assign w_neg_r   = w_dvd_s;
  assign w_quo_fix = r_neg_q ? w_quo_n : r_quo;
  assign w_rem_fix = r_neg_r ? w_rem_n : r_rem;
`else
  logic w_unused_sign;

  assign w_unused_sign = ^{op_signed, r_neg_q, r_neg_r};
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_neg_q   = 1'b0;
  assign w_neg_r   = 1'b0;
  assign w_quo_fix = r_quo;
  assign w_rem_fix = r_rem;
`endif

  // Shifted partial remainder can reach WIDTH+1 bits; the extra top bit is the borrow.
  assign w_trial        = {1'b0, r_rem, r_quo[WIDTH-1]} - {2'b00, r_dvs};
  assign w_unused_trial = w_trial[WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (divisor == '0) ? FIX : RUN;
      RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_dvd       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz_pend  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_dvd      <= dividend;
          r_dvs      <= w_dvs_mag;
          r_quo      <= w_dvd_mag;
          r_rem      <= '0;
          r_cnt      <= '0;
          r_neg_q    <= w_neg_q;
          r_neg_r    <= w_neg_r;
          r_dbz_pend <= (divisor == '0);
        end
        RUN: begin
          if (!w_trial[WIDTH+1]) r_rem <= w_trial[WIDTH-1:0];
          else                   r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_quotient  <= r_dbz_pend ? DBZ_Q : w_quo_fix;
          r_remainder <= r_dbz_pend ? r_dvd : w_rem_fix;
          r_dbz       <= r_dbz_pend;
          r_ready     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign ready       = r_ready;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: vector table plus reset-abort and
// back-to-back start sequences. Expectations follow the DIV_SIGNED_EN build setting.
module tb_iter_divider;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         op_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, ready, div_by_zero;
  logic [W-1:0] quotient, remainder;
  div_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[13];

  iter_divider #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .ready(ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .o_dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Driver: present a request on the falling edge; accepted at the next rising edge.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn);
    @(negedge clock);
    dividend  = dvd;
    divisor   = dvs;
    op_signed = sgn;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from acceptance to ready and how many of those samples saw busy.
  task automatic wait_ready(input string name, output int lat, output int bcnt);
    bit got;
    lat  = 0;
    bcnt = 0;
    got  = 0;
    while (!got && lat < 100) begin
      if (busy) bcnt++;
      if (ready) got = 1;
      else begin
        @(posedge clock);
        #1;
        lat++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no ready, expected ready within 100 cycles", name);
    end
  endtask

  initial begin
    int lat, bcnt;
    bit seen;
    logic [W-1:0] eq, er;

    vecs[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, LAT};
    vecs[2]  = '{32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1};
    vecs[3]  = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, LAT};
    vecs[4]  = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, LAT};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0, LAT};
    vecs[6]  = '{32'd1000000, 32'd1000, 1'b0, 32'd1000, 32'd0, 1'b0, LAT};
    vecs[7]  = '{32'hDEADBEEF, 32'h10, 1'b0, 32'h0DEADBEE, 32'hF, 1'b0, LAT};
    vecs[8]  = '{32'hFFFFFF9C, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1};
`ifdef DIV_SIGNED_EN
    vecs[9]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT};
    vecs[10] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, LAT};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, LAT};
    vecs[12] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0, LAT};
`else
    vecs[9]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0, LAT};
    vecs[10] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 1'b0, LAT};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0, LAT};
    vecs[12] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd0, 32'hFFFFFF9C, 1'b0, LAT};
`endif

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_ready", W'(ready), '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", W'(div_by_zero), '0);
    check("rst_state", W'(dbg_state), W'(IDLE));
    @(negedge clock);
    reset_n = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(vecs[i].q);
      exp_q.push_back(vecs[i].r);
      issue(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn);
      wait_ready($sformatf("vec%0d", i), lat, bcnt);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      check($sformatf("vec%0d_quotient", i), quotient, eq);
      check($sformatf("vec%0d_remainder", i), remainder, er);
      check($sformatf("vec%0d_dbz", i), W'(div_by_zero), W'(vecs[i].dbz));
      check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), W'(bcnt), W'(vecs[i].lat));
    end

    // Ready is a single-cycle pulse, results held afterwards
    @(posedge clock);
    #1;
    check("ready_pulse_width", W'(ready), '0);
    check("hold_quotient", quotient, vecs[12].q);

    // Reset mid-operation aborts with no ready pulse
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", W'(div_by_zero), '0);
    seen = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (ready) seen = 1;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready) seen = 1;
    end
    check("abort_no_ready", W'(seen), '0);
    issue(32'd9, 32'd3, 1'b0);
    wait_ready("after_abort", lat, bcnt);
    check("after_abort_quotient", quotient, 32'd3);
    check("after_abort_remainder", remainder, 32'd0);
    check("after_abort_latency", W'(lat), W'(LAT));

    // Start held high: ignored while busy, accepted again in the ready cycle
    @(negedge clock);
    dividend  = 32'd20;
    divisor   = 32'd6;
    op_signed = 1'b0;
    start     = 1'b1;
    @(posedge clock);
    #1;
    dividend = 32'd50;
    divisor  = 32'd7;
    repeat (5) @(posedge clock);
    #1;
    check("held_outputs_mid_op", quotient, 32'd3);
    wait_ready("b2b_first", lat, bcnt);
    check("b2b_first_quotient", quotient, 32'd3);
    check("b2b_first_remainder", remainder, 32'd2);
    check("b2b_first_latency", W'(lat), W'(LAT - 5));
    @(posedge clock);
    #1;
    start = 1'b0;
    check("b2b_second_accepted", W'(busy), 32'd1);
    check("b2b_ready_dropped", W'(ready), '0);
    wait_ready("b2b_second", lat, bcnt);
    check("b2b_second_quotient", quotient, 32'd7);
    check("b2b_second_remainder", remainder, 32'd1);
    check("b2b_second_latency", W'(lat), W'(LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle iterative integer divider for the processor's mult/div unit; it sits beside the ALU and executes DIV/DIVU. It takes operands from the register-read stage and returns quotient (LO) and remainder (HI) to the writeback path. It computes one restoring-division step per cycle under a start/ready handshake. Operand and result negation reuse the ALU's bitwise inverter followed by an increment.

## Interface
- WIDTH, 32, operand/result width in bits
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend  in  WIDTH  numerator, latched on accepted start
- divisor  in  WIDTH  denominator, latched on accepted start
- busy  out  1  high while in RUN or FIX
- ready  out  1  one-cycle pulse: results valid and updated
- quotient  out  WIDTH  LO result; held until next completion
- remainder  out  WIDTH  HI result; held until next completion
- div_by_zero  out  1  flag for the last completed operation

## Operation
- One clock; reset is asynchronous, active-low (reset_n).
- Reset values: busy=0, ready=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, counter=0.
- States: IDLE, RUN, FIX.
- IDLE, start=1: latch operands and sign bits, then check divisor.
  - divisor==0: go to FIX with the dbz flag set.
  - otherwise: load magnitudes (negate negative operands when signed), clear partial remainder, counter=0, go to RUN.
- RUN: shift {rem,quo} left by 1; trial = rem − |divisor| (WIDTH+1 bits). If non-negative, rem=trial and quo LSB=1. counter++. After WIDTH steps, go to FIX.
- FIX: apply signs; register quotient/remainder/div_by_zero; ready=1 for one cycle; go to IDLE.
  - Quotient is negated if sign(dividend)^sign(divisor).
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1.
- Signed overflow (0x80000000 / −1): wraps naturally to quotient=0x80000000, remainder=0, div_by_zero=0.
- start while busy is ignored and not queued.
- start in the ready cycle is accepted, since the state is IDLE; back-to-back operations are legal.
- Reset mid-operation aborts immediately: no ready pulse, all outputs return to reset values.

## Timing
- Accepted start at edge k.
- Normal operation: busy=1 from edge k through edge k+WIDTH+1; ready is high from edge k+WIDTH+1 to k+WIDTH+2. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: ready rises at edge k+1.
- Outputs change only on the ready edge.

## Configuration
- DIV_SIGNED_EN defined: op_signed is honoured, and the negation logic plus sign fix-up are built.
- DIV_SIGNED_EN undefined: op_signed is ignored and treated as 0, no negation logic is built, and latency is unchanged.

## Structure
- Shared package div_pkg holds:
  - state enum (IDLE, RUN, FIX)
  - default WIDTH
  - divide-by-zero quotient constant
  - counter width, $clog2(WIDTH+1)
- Sub-module div_negate: two's-complement negate built from the ALU bitwise inverter plus +1. Instantiate it once per operand/result use, only under DIV_SIGNED_EN.

## Test plan
- DIVU 100/7 → quotient=14, remainder=2, ready exactly 33 cycles after start, busy high for 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIV 7/0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- Divisor 0, dividend 0x12345678 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, ready 1 cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- reset_n low at iteration 10 → busy=0, no ready, outputs 0; after release, DIVU 9/3 → quotient=3, remainder=0.
- start held high throughout → second start accepted in the ready cycle; no start accepted while busy; with DIV_SIGNED_EN undefined, op_signed=1 on 0xFFFFFFF9/2 → quotient=0x7FFFFFFC, remainder=1.
